pixel_stream_fifo: RTL

PIXEL_STREAM_FIFO -- requirements
Module: pixel_stream_fifo

---
 rtl/pixel_stream_pkg.sv | 27 ++
 rtl/pixel_stream_fifo_ram.sv | 39 +++
 rtl/pixel_stream_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_pkg.sv
// -----------------------------------------------------------------------------
// pixel_stream_pkg
// Shared definitions for the pixel stream FIFO slice: default parameter
// constants, the stored word layout (payload plus sop/eop sideband) and a
// helper that returns the stored word width for a given payload width.
// No ports.
// -----------------------------------------------------------------------------
package pixel_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 24;
    localparam int unsigned DEF_DEPTH           = 8;
    localparam int unsigned DEF_ALMOST_EMPTY_TH = 2;
    localparam int unsigned SIDEBAND_BITS       = 2;

    // Stored word for the default payload width; the top re-declares the
    // same layout against its own DATA_WIDTH parameter.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      sop;
        logic                      eop;
    } pixel_word_t;

    function automatic int unsigned word_bits(input int unsigned data_width);
        return data_width + SIDEBAND_BITS;
    endfunction

endpackage

// File: rtl/pixel_stream_fifo_ram.sv
// -----------------------------------------------------------------------------
// pixel_stream_fifo_ram
// Simple dual-port storage array with a registered read port. The contents
// are never reset. A read of an address written on the same edge returns
// the old contents.
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write word
//   rd_addr_i  read address, sampled every edge
//   rd_data_o  registered read word
// -----------------------------------------------------------------------------
module pixel_stream_fifo_ram #(
    parameter  int unsigned WIDTH = 26,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_stream_fifo.sv
// -----------------------------------------------------------------------------
// pixel_stream_fifo
// First-word-fall-through FIFO for a pixel stream with packet sideband.
// Storage is pixel_stream_fifo_ram (registered read); the head word is kept
// on the RAM output register so a read presents the next word with no gap.
// Optional feature macro: PIXEL_STREAM_FIFO_PKT_COUNT_EN enables the count of
// complete packets held; without it pkt_count is tied to zero.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous clear, overrides handshakes
//   in_valid/in_ready       write handshake; in_ready is a register (!full)
//   in_data/in_sop/in_eop   write word
//   out_valid/out_ready     read handshake
//   out_data/out_sop/out_eop head word
//   fill_level              words held, 0..DEPTH
//   almost_full/almost_empty registered threshold flags
//   pkt_count               complete packets held
// -----------------------------------------------------------------------------
module pixel_stream_fifo
    import pixel_stream_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH           = DEF_DEPTH,
    parameter  int unsigned ALMOST_FULL_TH  = DEPTH - 2,
    parameter  int unsigned ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH,
    localparam int unsigned AW              = $clog2(DEPTH),
    localparam int unsigned CW              = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [CW-1:0]         fill_level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         pkt_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } word_t;

    localparam int unsigned   WW       = word_bits(DATA_WIDTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_TH);

    logic          wr;
    logic          rd;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          out_valid_q, out_valid_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          byp_sel_q, byp_sel_d;
    word_t         byp_q;
    word_t         wr_word;
    word_t         out_word;
    logic [WW-1:0] ram_rd;

    assign wr      = in_valid && !full_q && !flush;
    assign rd      = out_valid_q && out_ready && !flush;
    assign wr_word = '{data: in_data, sop: in_sop, eop: in_eop};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        byp_sel_d   = 1'b0;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            full_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr, rd})
                2'b10: begin
                    level_d = level_q + CW'(1);
                    full_d  = (level_q == FULL_LVL - CW'(1));
                end
                2'b01: begin
                    level_d = level_q - CW'(1);
                    full_d  = 1'b0;
                end
                default: ;
            endcase
            // The RAM can only return words that were already stored before
            // this edge. When the last held word is read while a new one is
            // written, the new word is forwarded from the bypass register for
            // one cycle; after that the RAM output holds the same word.
            out_valid_d = (level_q > CW'(rd)) || (rd && wr);
            byp_sel_d   = rd && wr && (level_q == CW'(1));
        end
        af_d = (level_d >= AF_LVL);
        ae_d = (level_d <= AE_LVL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            byp_sel_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            byp_sel_q   <= byp_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        byp_q <= wr_word;
    end

    pixel_stream_fifo_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_word),
        .rd_addr_i (rd_ptr_d),
        .rd_data_o (ram_rd)
    );

    assign out_word = byp_sel_q ? byp_q : word_t'(ram_rd);

`ifdef PIXEL_STREAM_FIFO_PKT_COUNT_EN
    logic [CW-1:0] pkt_q, pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        if (flush) begin
            pkt_d = '0;
        end else begin
            case ({wr && in_eop, rd && out_word.eop})
                2'b10:   pkt_d = pkt_q + CW'(1);
                2'b01:   pkt_d = pkt_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pkt_q <= '0;
        else          pkt_q <= pkt_d;
    end

    assign pkt_count = pkt_q;
`else
    assign pkt_count = '0;
`endif

    assign in_ready     = !full_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_word.data;
    assign out_sop      = out_word.sop;
    assign out_eop      = out_word.eop;
    assign fill_level   = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule
